// File: rtl/cpu_pipeline_fwd.sv
// cpu_pipeline_fwd: 5-stage in-order core (F/D/E/M/W) with full operand forwarding,
// a load-use interlock and a bus wait-state freeze. Define CPU_PERF_COUNTERS_EN for perf counters.
module cpu_pipeline_fwd #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    output logic [ADDR_WIDTH-1:0] o_pc,
    input  logic [31:0]           i_instruction,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_mem_ready,
    output logic                  o_debug_stall,
    output logic                  o_debug_freeze,
    output logic [31:0]           o_perf_retired,
    output logic [31:0]           o_perf_stalls
);

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LW   = 3'd1,
        OP_SW   = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_ADDI = 3'd5
    } op_t;

    // Bit i set when register index i is architecturally writable (r0 and indices >= NUM_REGS are not).
    localparam logic [16:0] REG_ONES  = (17'd1 << NUM_REGS) - 17'd1;
    localparam logic [15:0] REG_VALID = REG_ONES[15:0] & 16'hFFFE;

    // Fetch / decode registers
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           ir_q;

    // Execute stage registers
    op_t                   op_e_q;
    logic [3:0]            rd_e_q, rs1_e_q, rs2_e_q;
    logic                  we_e_q;
    logic [DATA_WIDTH-1:0] a_e_q, b_e_q, s_e_q, imm_e_q;

    // Memory stage registers
    op_t                   op_m_q;
    logic [3:0]            rd_m_q;
    logic                  we_m_q;
    logic [DATA_WIDTH-1:0] alu_m_q, sd_m_q;

    // Writeback stage registers
    logic [3:0]            rd_w_q;
    logic                  we_w_q;
    logic [DATA_WIDTH-1:0] wdata_w_q, wdata_d;

    logic [DATA_WIDTH-1:0] regs_q [16];

    // Decode
    op_t                   op_d;
    logic [3:0]            rd_d, rs1_d, rs2_d;
    logic [DATA_WIDTH-1:0] imm_d, rd_val_d, rs1_val_d, rs2_val_d;
    logic                  we_d, uses_rs1_d, uses_rs2_d, uses_rd_d;

    always_comb begin
        op_d = OP_NOP;
        case (ir_q[31:24])
            8'd1:    op_d = OP_LW;
            8'd2:    op_d = OP_SW;
            8'd3:    op_d = OP_ADD;
            8'd4:    op_d = OP_SUB;
            8'd5:    op_d = OP_ADDI;
            default: op_d = OP_NOP;
        endcase
    end

    assign rd_d       = ir_q[23:20];
    assign rs1_d      = ir_q[19:16];
    assign rs2_d      = ir_q[15:12];
    assign imm_d      = DATA_WIDTH'(ir_q[15:0]);
    assign we_d       = (op_d == OP_LW || op_d == OP_ADD || op_d == OP_SUB || op_d == OP_ADDI)
                        && REG_VALID[rd_d];
    assign uses_rs1_d = (op_d != OP_NOP);
    assign uses_rs2_d = (op_d == OP_ADD || op_d == OP_SUB);
    assign uses_rd_d  = (op_d == OP_SW);

    // Register reads with write-through from the instruction currently in W
    assign rs1_val_d = !REG_VALID[rs1_d] ? '0 :
                       (we_w_q && rd_w_q == rs1_d) ? wdata_w_q : regs_q[rs1_d];
    assign rs2_val_d = !REG_VALID[rs2_d] ? '0 :
                       (we_w_q && rd_w_q == rs2_d) ? wdata_w_q : regs_q[rs2_d];
    assign rd_val_d  = !REG_VALID[rd_d] ? '0 :
                       (we_w_q && rd_w_q == rd_d) ? wdata_w_q : regs_q[rd_d];

    // Execute operand forwarding: M (non-load) has priority over W
    logic                  m_fwd_ok;
    logic [DATA_WIDTH-1:0] a_fwd, b_fwd, s_fwd, alu_e;

    assign m_fwd_ok = we_m_q && (op_m_q != OP_LW);
    assign a_fwd = (m_fwd_ok && rd_m_q == rs1_e_q) ? alu_m_q :
                   (we_w_q && rd_w_q == rs1_e_q) ? wdata_w_q : a_e_q;
    assign b_fwd = (m_fwd_ok && rd_m_q == rs2_e_q) ? alu_m_q :
                   (we_w_q && rd_w_q == rs2_e_q) ? wdata_w_q : b_e_q;
    assign s_fwd = (m_fwd_ok && rd_m_q == rd_e_q) ? alu_m_q :
                   (we_w_q && rd_w_q == rd_e_q) ? wdata_w_q : s_e_q;

    always_comb begin
        alu_e = '0;
        case (op_e_q)
            OP_LW, OP_SW, OP_ADDI: alu_e = a_fwd + imm_e_q;
            OP_ADD:                alu_e = a_fwd + b_fwd;
            OP_SUB:                alu_e = a_fwd - b_fwd;
            default:               alu_e = '0;
        endcase
    end

    // Hazard control
    logic mem_req, freeze, load_use, stall;

    assign mem_req  = (op_m_q == OP_LW) || (op_m_q == OP_SW);
    assign freeze   = mem_req && !i_mem_ready;
    assign load_use = (op_e_q == OP_LW) && (rd_e_q != 4'd0) &&
                      ((uses_rs1_d && rs1_d == rd_e_q) ||
                       (uses_rs2_d && rs2_d == rd_e_q) ||
                       (uses_rd_d  && rd_d  == rd_e_q));
    assign stall    = load_use && !freeze;

    assign pc_d    = pc_q + ADDR_WIDTH'(4);
    assign wdata_d = (op_m_q == OP_LW) ? i_data : alu_m_q;

    // Pipeline registers; a freeze holds every stage including W
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q      <= '0;
            ir_q      <= '0;
            op_e_q    <= OP_NOP;
            rd_e_q    <= '0;
            rs1_e_q   <= '0;
            rs2_e_q   <= '0;
            we_e_q    <= 1'b0;
            a_e_q     <= '0;
            b_e_q     <= '0;
            s_e_q     <= '0;
            imm_e_q   <= '0;
            op_m_q    <= OP_NOP;
            rd_m_q    <= '0;
            we_m_q    <= 1'b0;
            alu_m_q   <= '0;
            sd_m_q    <= '0;
            rd_w_q    <= '0;
            we_w_q    <= 1'b0;
            wdata_w_q <= '0;
        end else if (!freeze) begin
            if (!stall) begin
                pc_q <= pc_d;
                ir_q <= i_instruction;
            end
            if (stall) begin
                op_e_q <= OP_NOP;
                rd_e_q <= '0;
                we_e_q <= 1'b0;
            end else begin
                op_e_q  <= op_d;
                rd_e_q  <= rd_d;
                rs1_e_q <= rs1_d;
                rs2_e_q <= rs2_d;
                we_e_q  <= we_d;
                a_e_q   <= rs1_val_d;
                b_e_q   <= rs2_val_d;
                s_e_q   <= rd_val_d;
                imm_e_q <= imm_d;
            end
            op_m_q    <= op_e_q;
            rd_m_q    <= rd_e_q;
            we_m_q    <= we_e_q;
            alu_m_q   <= alu_e;
            sd_m_q    <= s_fwd;
            rd_w_q    <= rd_m_q;
            we_w_q    <= we_m_q;
            wdata_w_q <= wdata_d;
        end
    end

    // Register file, written at the end of W
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (!freeze && we_w_q) begin
            regs_q[rd_w_q] <= wdata_w_q;
        end
    end

    assign o_pc           = pc_q;
    assign o_mem_req      = mem_req;
    assign o_mem_we       = (op_m_q == OP_SW);
    assign o_address      = mem_req ? alu_m_q[ADDR_WIDTH-1:0] : '0;
    assign o_data         = (op_m_q == OP_SW) ? sd_m_q : '0;
    assign o_debug_stall  = stall;
    assign o_debug_freeze = freeze;

`ifdef CPU_PERF_COUNTERS_EN
    op_t         op_w_q;
    logic [31:0] retired_q, stalls_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            op_w_q    <= OP_NOP;
            retired_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (!freeze) begin
                op_w_q <= op_m_q;
                if (op_w_q != OP_NOP) begin
                    retired_q <= retired_q + 32'd1;
                end
            end
            if (stall || freeze) begin
                stalls_q <= stalls_q + 32'd1;
            end
        end
    end

    assign o_perf_retired = retired_q;
    assign o_perf_stalls  = stalls_q;
`else
    assign o_perf_retired = 32'd0;
    assign o_perf_stalls  = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_pipeline_fwd.sv
// Directed self-checking bench for cpu_pipeline_fwd: forwarding, stores, load-use,
// wait-state freeze, freeze-over-stall, r0 and mid-access reset.
module tb_cpu_pipeline_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] o_pc;
    logic [31:0] i_instruction;
    logic        o_mem_req, o_mem_we;
    logic [15:0] o_address;
    logic [31:0] o_data, i_data;
    logic        rdy;
    logic        o_debug_stall, o_debug_freeze;
    logic [31:0] o_perf_retired, o_perf_stalls;

    logic [31:0] prog [32];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stall_cycles = 0;
    int          freeze_cycles = 0;

`ifdef CPU_PERF_COUNTERS_EN
    localparam logic [31:0] EXP_RETIRED = 32'd2;
    localparam logic [31:0] EXP_PSTALLS = 32'd1;
`else
    localparam logic [31:0] EXP_RETIRED = 32'd0;
    localparam logic [31:0] EXP_PSTALLS = 32'd0;
`endif

    cpu_pipeline_fwd dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .o_pc           (o_pc),
        .i_instruction  (i_instruction),
        .o_mem_req      (o_mem_req),
        .o_mem_we       (o_mem_we),
        .o_address      (o_address),
        .o_data         (o_data),
        .i_data         (i_data),
        .i_mem_ready    (rdy),
        .o_debug_stall  (o_debug_stall),
        .o_debug_freeze (o_debug_freeze),
        .o_perf_retired (o_perf_retired),
        .o_perf_stalls  (o_perf_stalls)
    );

    always #5 clk = ~clk;

    always_comb i_instruction = prog[o_pc[6:2]];
    always_comb i_data = (o_address == 16'h0010) ? 32'h0000_1234 : {16'hDEAD, o_address};

    always @(negedge clk) begin
        if (!rst) begin
            if (o_debug_stall)  stall_cycles++;
            if (o_debug_freeze) freeze_cycles++;
        end
    end

    function automatic logic [31:0] enc(input logic [7:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] add_i(input logic [3:0] rd, input logic [3:0] rs1,
                                          input logic [3:0] rs2);
        return {8'd3, rd, rs1, rs2, 12'h000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_scn();
        rst = 1'b1;
        rdy = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) prog[i] = 32'h0;
    endtask

    task automatic release_rst();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        stall_cycles = 0;
        freeze_cycles = 0;
    endtask

    initial begin
        // Scenario 1: back-to-back ADDI/ADDI/ADD, result stored twice
        begin_scn();
        prog[0] = enc(8'd5, 4'd1, 4'd0, 16'h0005);
        prog[1] = enc(8'd5, 4'd2, 4'd0, 16'h0007);
        prog[2] = add_i(4'd3, 4'd1, 4'd2);
        prog[3] = enc(8'd2, 4'd3, 4'd0, 16'h0080);
        prog[6] = enc(8'd2, 4'd3, 4'd0, 16'h0084);
        @(posedge clk); #1;
        chk("rst_pc", 32'(o_pc), 32'h0);
        chk("rst_req", 32'(o_mem_req), 32'h0);
        chk("rst_addr", 32'(o_address), 32'h0);
        chk("rst_data", o_data, 32'h0);
        chk("rst_stall", 32'({o_debug_stall, o_debug_freeze, o_mem_we}), 32'h0);
        chk("rst_perf", o_perf_retired | o_perf_stalls, 32'h0);
        release_rst();
        run_to(5);
        chk("s1_add_in_m_req", 32'(o_mem_req), 32'h0);
        run_to(6);
        chk("s1_fwd_m_addr", 32'(o_address), 32'h80);
        chk("s1_fwd_m_data", o_data, 32'd12);
        run_to(9);
        chk("s1_rf_addr", 32'(o_address), 32'h84);
        chk("s1_rf_data", o_data, 32'd12);
        chk("s1_no_stall", 32'(stall_cycles), 32'd0);

        // Scenario 2: ADDI r1,0x40 ; SW r1,[r1+0]
        begin_scn();
        prog[0] = enc(8'd5, 4'd1, 4'd0, 16'h0040);
        prog[1] = enc(8'd2, 4'd1, 4'd1, 16'h0000);
        release_rst();
        run_to(3);
        chk("s2_pre_req", 32'(o_mem_req), 32'h0);
        chk("s2_pre_data", o_data, 32'h0);
        run_to(4);
        chk("s2_req_we", 32'({o_mem_req, o_mem_we}), 32'h3);
        chk("s2_addr", 32'(o_address), 32'h40);
        chk("s2_data", o_data, 32'h40);
        run_to(5);
        chk("s2_post_req", 32'(o_mem_req), 32'h0);

        // Scenario 3: LW r2,[r0+0x10] ; ADD r3,r2,r2 ; SW r3,[r0+0x80]
        begin_scn();
        prog[0] = enc(8'd1, 4'd2, 4'd0, 16'h0010);
        prog[1] = add_i(4'd3, 4'd2, 4'd2);
        prog[2] = enc(8'd2, 4'd3, 4'd0, 16'h0080);
        release_rst();
        run_to(1);
        chk("s3_c1_stall", 32'(o_debug_stall), 32'h0);
        run_to(2);
        chk("s3_c2_stall", 32'(o_debug_stall), 32'h1);
        chk("s3_c2_pc", 32'(o_pc), 32'h8);
        run_to(3);
        chk("s3_c3_stall", 32'(o_debug_stall), 32'h0);
        chk("s3_c3_pc", 32'(o_pc), 32'h8);
        chk("s3_lw_req_we", 32'({o_mem_req, o_mem_we}), 32'h2);
        chk("s3_lw_addr", 32'(o_address), 32'h10);
        run_to(6);
        chk("s3_sw_addr", 32'(o_address), 32'h80);
        chk("s3_sw_data", o_data, 32'h2468);
        run_to(7);
        chk("s3_stall_cnt", 32'(stall_cycles), 32'd1);
        chk("s3_perf_retired", o_perf_retired, EXP_RETIRED);
        chk("s3_perf_stalls", o_perf_stalls, EXP_PSTALLS);

        // Scenario 4: LW with three wait states, then SW of the loaded value
        begin_scn();
        prog[0] = enc(8'd1, 4'd4, 4'd0, 16'h0010);
        prog[4] = enc(8'd2, 4'd4, 4'd0, 16'h0090);
        release_rst();
        run_to(3);
        rdy = 1'b0;
        #1;
        chk("s4_c3_freeze", 32'(o_debug_freeze), 32'h1);
        chk("s4_c3_pc", 32'(o_pc), 32'hC);
        chk("s4_c3_addr", 32'(o_address), 32'h10);
        run_to(5);
        chk("s4_c5_freeze", 32'(o_debug_freeze), 32'h1);
        chk("s4_c5_pc", 32'(o_pc), 32'hC);
        chk("s4_c5_addr", 32'(o_address), 32'h10);
        chk("s4_c5_req", 32'({o_mem_req, o_mem_we}), 32'h2);
        run_to(6);
        rdy = 1'b1;
        #1;
        chk("s4_c6_freeze", 32'(o_debug_freeze), 32'h0);
        chk("s4_c6_pc", 32'(o_pc), 32'hC);
        run_to(10);
        chk("s4_sw_addr", 32'(o_address), 32'h90);
        chk("s4_sw_data", o_data, 32'h1234);
        chk("s4_freeze_cnt", 32'(freeze_cycles), 32'd3);
        chk("s4_stall_cnt", 32'(stall_cycles), 32'd0);

        // Scenario 5: load-use pending while an earlier SW waits; bubble after the freeze
        begin_scn();
        prog[0] = enc(8'd2, 4'd0, 4'd0, 16'h0020);
        prog[1] = enc(8'd1, 4'd4, 4'd0, 16'h0010);
        prog[2] = add_i(4'd5, 4'd4, 4'd4);
        prog[5] = enc(8'd2, 4'd5, 4'd0, 16'h0094);
        release_rst();
        run_to(3);
        rdy = 1'b0;
        #1;
        chk("s5_c3_freeze", 32'(o_debug_freeze), 32'h1);
        chk("s5_c3_stall", 32'(o_debug_stall), 32'h0);
        chk("s5_c3_addr", 32'(o_address), 32'h20);
        run_to(5);
        rdy = 1'b1;
        #1;
        chk("s5_c5_freeze", 32'(o_debug_freeze), 32'h0);
        chk("s5_c5_stall", 32'(o_debug_stall), 32'h1);
        run_to(6);
        chk("s5_c6_stall", 32'(o_debug_stall), 32'h0);
        chk("s5_c6_lw_addr", 32'(o_address), 32'h10);
        run_to(11);
        chk("s5_sw_addr", 32'(o_address), 32'h94);
        chk("s5_sw_data", o_data, 32'h2468);
        chk("s5_stall_cnt", 32'(stall_cycles), 32'd1);

        // Scenario 6: r0 is hardwired to zero; reset during an active store
        begin_scn();
        prog[0] = enc(8'd5, 4'd0, 4'd0, 16'h0009);
        prog[1] = add_i(4'd1, 4'd0, 4'd0);
        prog[2] = enc(8'd2, 4'd1, 4'd0, 16'h0080);
        prog[3] = enc(8'd2, 4'd0, 4'd0, 16'h0084);
        prog[5] = enc(8'd2, 4'd0, 4'd0, 16'h0088);
        release_rst();
        run_to(5);
        chk("s6_r1_addr", 32'(o_address), 32'h80);
        chk("s6_r1_data", o_data, 32'h0);
        run_to(6);
        chk("s6_r0_fwd_data", o_data, 32'h0);
        run_to(8);
        chk("s6_r0_rf_addr", 32'(o_address), 32'h88);
        chk("s6_r0_rf_data", o_data, 32'h0);
        rdy = 1'b0;
        #1;
        chk("s6_active_req", 32'({o_mem_req, o_debug_freeze}), 32'h3);
        rst = 1'b1;
        #1;
        chk("s6_rst_req", 32'(o_mem_req), 32'h0);
        chk("s6_rst_pc", 32'(o_pc), 32'h0);
        chk("s6_rst_bus", 32'(o_address) | o_data, 32'h0);
        chk("s6_rst_freeze", 32'(o_debug_freeze), 32'h0);
        rdy = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
